// File: rtl/excess3_digit_collector.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | excess3_digit_collector                                                  |
// | Serial LSB-first Excess-3 deserialiser feeding a DEPTH-entry digit FIFO. |
// | Optional code checking when EXCESS3_CHECK_EN is defined.                 |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module excess3_digit_collector #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       sync_clr,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic       code_err,
  output logic       overflow
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [1:0]       pos_q, pos_d;
  logic [2:0]       partial_q, partial_d;
  logic [3:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, write, full;
  logic [3:0]       new_digit;

  assign digit_valid = (count_q != '0);
  assign digit_out   = mem_q[rd_ptr_q];
  assign overflow    = overflow_q;

  always_comb begin
    pos_d     = pos_q;
    partial_d = partial_q;
    push      = 1'b0;
    new_digit = {bit_in, partial_q};
    // Realign wins over a coincident valid bit.
    if (sync_clr) begin
      pos_d     = 2'd0;
      partial_d = 3'd0;
    end else if (bit_valid) begin
      pos_d = pos_q + 2'd1;
      case (pos_q)
        2'd0:    partial_d[0] = bit_in;
        2'd1:    partial_d[1] = bit_in;
        2'd2:    partial_d[2] = bit_in;
        default: push         = 1'b1;
      endcase
    end
  end

  always_comb begin
    full       = (count_q == FULL_CNT);
    pop        = digit_valid && digit_ready;
    // A pop on the same edge frees the slot for a push into a full buffer.
    write      = push && (!full || pop);
    overflow_d = push && full && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (write) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({write, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pos_q      <= 2'd0;
      partial_q  <= 3'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 4'd0;
      end
    end else begin
      pos_q      <= pos_d;
      partial_q  <= partial_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (write) begin
        mem_q[wr_ptr_q] <= new_digit;
      end
    end
  end

`ifdef EXCESS3_CHECK_EN
  logic err_q [DEPTH];
  logic new_err;

  // Legal Excess-3 codes span 0011 (digit 0) to 1100 (digit 9).
  assign new_err  = (new_digit < 4'd3) || (new_digit > 4'd12);
  assign code_err = err_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        err_q[i] <= 1'b0;
      end
    end else if (write) begin
      err_q[wr_ptr_q] <= new_err;
    end
  end
`else
  assign code_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_excess3_digit_collector.sv
`default_nettype none
// Directed bench for excess3_digit_collector with a queue-based reference model.
module tb_excess3_digit_collector;

  localparam int DEPTH = 2;
`ifdef EXCESS3_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk         = 1'b0;
  logic       reset_b     = 1'b1;
  logic       bit_in      = 1'b0;
  logic       bit_valid   = 1'b0;
  logic       sync_clr    = 1'b0;
  logic       digit_ready = 1'b0;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       code_err;
  logic       overflow;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  excess3_digit_collector #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .sync_clr   (sync_clr),
    .digit_out  (digit_out),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .code_err   (code_err),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: digits as plain queue entries, bits collected by index.
  logic [3:0] m_q[$];
  logic       m_e[$];
  int         m_pos  = 0;
  logic [3:0] m_bits = 4'd0;
  logic       m_ovf  = 1'b0;
  logic       m_pop;
  logic       m_have;

  function automatic logic bad_code(input logic [3:0] d);
    return CHK && ((d < 4'd3) || (d > 4'd12));
  endfunction

  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      m_q.delete();
      m_e.delete();
      m_pos = 0;
      m_ovf = 1'b0;
    end else begin
      m_pop  = (m_q.size() != 0) && digit_ready;
      m_have = 1'b0;
      m_ovf  = 1'b0;
      if (sync_clr) begin
        m_pos = 0;
      end else if (bit_valid) begin
        m_bits[m_pos] = bit_in;
        if (m_pos == 3) begin
          m_have = 1'b1;
          m_pos  = 0;
        end else begin
          m_pos++;
        end
      end
      if (m_pop) begin
        void'(m_q.pop_front());
        void'(m_e.pop_front());
      end
      if (m_have) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(m_bits);
          m_e.push_back(bad_code(m_bits));
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_valid", {3'b0, digit_valid}, {3'b0, m_q.size() != 0});
    check("model_overflow", {3'b0, overflow}, {3'b0, m_ovf});
    if (m_q.size() != 0) begin
      check("model_head", digit_out, m_q[0]);
      check("model_err", {3'b0, code_err}, {3'b0, m_e[0]});
    end
  end

  task automatic step(input logic bv, input logic b, input logic clr, input logic rdy);
    @(negedge clk);
    bit_valid   = bv;
    bit_in      = b;
    sync_clr    = clr;
    digit_ready = rdy;
  endtask

  task automatic send(input logic [3:0] d, input logic rdy);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, d[i], 1'b0, rdy);
    end
  endtask

  task automatic expect_head(input string name, input logic [3:0] d, input logic err);
    check({name, "_valid"}, {3'b0, digit_valid}, 4'd1);
    check({name, "_digit"}, digit_out, d);
    check({name, "_err"}, {3'b0, code_err}, {3'b0, err});
  endtask

  task automatic expect_empty(input string name);
    check({name, "_valid"}, {3'b0, digit_valid}, 4'd0);
  endtask

  initial begin
    #1 reset_b = 1'b0;
    #1;
    check("reset_digit", digit_out, 4'b0000);
    check("reset_valid", {3'b0, digit_valid}, 4'd0);
    check("reset_err", {3'b0, code_err}, 4'd0);
    check("reset_ovf", {3'b0, overflow}, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    reset_b = 1'b1;

    // Single digit with consumer ready
    send(4'b0011, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    expect_head("s1", 4'b0011, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    expect_empty("s1_after");

    // Two digits held, then drained in order
    send(4'b1100, 1'b0);
    send(4'b0110, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_head("s2_first", 4'b1100, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    expect_head("s2_first_hold", 4'b1100, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    expect_head("s2_second", 4'b0110, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_empty("s2_after");

    // Overflow on a full buffer
    send(4'b0011, 1'b0);
    send(4'b0100, 1'b0);
    send(4'b0101, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("s3_ovf_pulse", {3'b0, overflow}, 4'd1);
    expect_head("s3_head", 4'b0011, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("s3_ovf_end", {3'b0, overflow}, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    expect_head("s3_second", 4'b0100, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_empty("s3_after");

    // Push and pop on the same edge with a full buffer
    send(4'b0011, 1'b0);
    send(4'b0100, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("s4_no_ovf", {3'b0, overflow}, 4'd0);
    expect_head("s4_head", 4'b0100, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    expect_head("s4_tail", 4'b0111, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_empty("s4_after");

    // Realign discards partial bits and the coincident bit
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    expect_empty("s5_partial");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_head("s5_digit", 4'b0101, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_empty("s5_after");

    // Invalid codes below and above the legal range
    send(4'b0000, 1'b0);
    send(4'b1101, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_head("s6_low", 4'b0000, CHK);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_head("s6_high", 4'b1101, CHK);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_empty("s6_after");

    // Asynchronous reset mid-digit with a non-empty buffer
    send(4'b0100, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    reset_b   = 1'b0;
    bit_valid = 1'b0;
    #1;
    check("s7_rst_digit", digit_out, 4'b0000);
    check("s7_rst_valid", {3'b0, digit_valid}, 4'd0);
    check("s7_rst_ovf", {3'b0, overflow}, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    reset_b = 1'b1;
    send(4'b0110, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_head("s7_digit", 4'b0110, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_empty("s7_after");

    step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/excess3_digit_collector.md
EXCESS3_DIGIT_COLLECTOR -- requirements
Module: excess3_digit_collector

Interface
REQ-001 The parameter list SHALL be: DEPTH, default 2, number of digit entries in the output buffer (legal values 2 or 4).
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-003 The port reset_b SHALL be an input, 1 bit wide: the reset, asynchronous, active-low.
REQ-004 The port bit_in SHALL be an input, 1 bit wide, carrying the serial Excess-3 bit stream, LSB first, 4 bits per digit.
REQ-005 The port bit_valid SHALL be an input, 1 bit wide, qualifying bit_in on the current clock edge.
REQ-006 The port sync_clr SHALL be an input, 1 bit wide, a synchronous realign that discards any partial digit.
REQ-007 The port digit_out SHALL be an output, 4 bits wide, carrying the assembled Excess-3 digit at the buffer head.
REQ-008 The port digit_valid SHALL be an output, 1 bit wide, asserted when the buffer is non-empty.
REQ-009 The port digit_ready SHALL be an input, 1 bit wide: the consumer accepts the head digit when both digit_valid and digit_ready are 1.
REQ-010 The port code_err SHALL be an output, 1 bit wide, flagging the head digit as an invalid Excess-3 code; it is qualified by digit_valid.
REQ-011 The port overflow SHALL be an output, 1 bit wide, a one-cycle pulse that signals a completed digit was dropped.

Function
REQ-012 A 2-bit position counter SHALL advance on each edge with bit_valid=1, storing bit_in at weight 2^position and wrapping from 3 to 0.
REQ-013 On the edge where position=3 and bit_valid=1, the digit {bit_in, stored[2:0]} SHALL be pushed to the buffer.
REQ-014 Latency: the digit SHALL be visible on digit_out with digit_valid=1 one cycle after the 4th bit edge when the buffer was empty.
REQ-015 The buffer SHALL be a DEPTH-entry FIFO, first-in first-out, with wrap-around read and write pointers and an occupancy count of width clog2(DEPTH)+1.
REQ-016 A pop SHALL occur on an edge with digit_valid=1 and digit_ready=1; digit_out and code_err SHALL change only on a pop or on a push into an empty buffer.
REQ-017 When a push occurs and the buffer is full with no pop on the same edge, the digit SHALL be dropped, overflow SHALL be 1 for exactly the next cycle, and the contents SHALL be unchanged.
REQ-018 When a push and a pop occur on the same edge with the buffer full, both SHALL be accepted and occupancy SHALL stay at DEPTH with no overflow.
REQ-019 When a push and a pop occur on the same edge with the buffer empty, that case is impossible because digit_valid=0; a push alone SHALL occur.
REQ-020 When sync_clr=1, the position counter SHALL be set to 0 and the partial bits discarded; bit_valid on that same edge SHALL be ignored; buffer, pops and overflow SHALL be unaffected.
REQ-021 When bit_valid=0, the position counter and partial bits SHALL hold.

Reset
REQ-022 Assertion of reset_b=0 SHALL immediately set position to 0, empty the buffer, and drive digit_out=4'b0000, digit_valid=0, code_err=0 and overflow=0, regardless of clk.
REQ-023 Reset asserted mid-digit SHALL discard the partial bits; the first bit_valid edge after release SHALL be taken as bit position 0.

Configuration
REQ-024 When the macro EXCESS3_CHECK_EN is defined, each pushed digit SHALL store err=1 if its code is outside 4'b0011..4'b1100, and code_err SHALL present the head entry's err.
REQ-025 When EXCESS3_CHECK_EN is undefined, the err storage and comparator SHALL be absent and code_err SHALL be tied to 0.

Verification
REQ-026 Scenario: reset, then bits 1,1,0,0 with bit_valid=1 and ready=1 -> digit_out=0011 and digit_valid=1 for one cycle, one cycle after the 4th bit.
REQ-027 Scenario: stream digits 1100 then 0110 (bits 0,0,1,1,0,1,1,0) with ready=0 -> the head is 1100; after ready=1 the pops yield 1100 then 0110 in order.
REQ-028 Scenario: DEPTH=2, ready=0, three digits 0011/0100/0101 -> overflow pulses after the 12th bit; the buffer then holds 0011 and 0100 only.
REQ-029 Scenario: with a full buffer and ready=1 on the 4th-bit edge of digit 0111 -> no overflow, and 0111 becomes the tail.
REQ-030 Scenario: 2 bits, then sync_clr=1 (with bit_valid=1), then bits 1,0,1,0 -> digit_out=0101 is the only digit produced.
REQ-031 Scenario: with EXCESS3_CHECK_EN defined, stream 0000 then 1101 -> code_err=1 for both; with it undefined -> code_err=0 for both.
